// File: rtl/slv_chnl_fifo.sv
// Slave channel FIFO: show-ahead word buffer between an initiator and a downstream arbiter.
// Optional peak-occupancy statistic enabled by defining SLV_PEAK_STAT_EN.
module slv_chnl_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       valid_i,
  input  logic [DW-1:0]              data_i,
  output logic                       ready_o,
  output logic                       req_o,
  input  logic                       ack_i,
  output logic [DW-1:0]              data_o,
  output logic [$clog2(DEPTH):0]     margin_o
`ifdef SLV_PEAK_STAT_EN
  ,
  output logic [$clog2(DEPTH):0]     peak_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  assign full  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
  assign empty = (wrPtr_q == rdPtr_q);
  assign count = wrPtr_q - rdPtr_q;

  assign ready_o  = en_i && !full && !rst;
  assign req_o    = en_i && !empty;
  assign push     = valid_i && ready_o;
  assign pop      = ack_i && req_o;
  assign data_o   = mem[rdPtr_q[AW-1:0]];
  assign margin_o = DEPTH_C - count;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) wrPtr_d = wrPtr_q + PTR_ONE;
    if (pop)  rdPtr_d = rdPtr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage is deliberately not reset; stale words are hidden while req_o is low.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q[AW-1:0]] <= data_i;
  end

`ifdef SLV_PEAK_STAT_EN
  logic [CW-1:0] peak_q, peak_d;
  logic [CW-1:0] nextCount;

  assign nextCount = wrPtr_d - rdPtr_d;

  always_comb begin
    peak_d = peak_q;
    if (nextCount > peak_q) peak_d = nextCount;
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak_o = peak_q;
`endif

endmodule

// File: tb/tb_slv_chnl_fifo.sv
// Self-checking bench for slv_chnl_fifo: vector table plus directed multi-cycle sequences.
// Peak statistic checks are compiled in only when SLV_PEAK_STAT_EN is defined.
module tb_slv_chnl_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic          en_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          req_o;
  logic          ack_i;
  logic [DW-1:0] data_o;
  logic [5:0]    margin_o;
`ifdef SLV_PEAK_STAT_EN
  logic [5:0]    peak_o;
`endif

  int total = 0;
  int bad   = 0;

  slv_chnl_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en_i),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .req_o    (req_o),
    .ack_i    (ack_i),
    .data_o   (data_o),
    .margin_o (margin_o)
`ifdef SLV_PEAK_STAT_EN
    ,
    .peak_o   (peak_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        valid;
    logic [31:0] data;
    logic        ack;
    logic        expReady;
    logic        expReq;
    logic        chkData;
    logic [31:0] expData;
    logic [5:0]  expMargin;
  } vec_t;

  vec_t vecs[14];

  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic [31:0] d, input logic a);
    rst     = r;
    en_i    = e;
    valid_i = v;
    data_i  = d;
    ack_i   = a;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs applied, outputs checked before the edge, then one clock.
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  6'd32};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 6'd31};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 6'd30};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h11, 6'd29};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h22, 6'd30};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h33, 6'd31};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  6'd32};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  6'd32};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  6'd32};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  6'd32};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  6'd32};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h77, 6'd31};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h77, 6'd31};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  6'd32};

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick;
    tick;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("reset_ready", ready_o, 1'b0);
    checkOutput("reset_req", req_o, 1'b0);
    checkOutput("reset_margin", margin_o, 6'd32);
`ifdef SLV_PEAK_STAT_EN
    checkOutput("reset_peak", peak_o, 6'd0);
`endif

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].data, vecs[i].ack);
      checkOutput($sformatf("vec%0d_ready", i), ready_o, vecs[i].expReady);
      checkOutput($sformatf("vec%0d_req", i), req_o, vecs[i].expReq);
      checkOutput($sformatf("vec%0d_margin", i), margin_o, vecs[i].expMargin);
      if (vecs[i].chkData) checkOutput($sformatf("vec%0d_data", i), data_o, vecs[i].expData);
      tick;
    end

    // Fill to full across the pointer wrap, then hold off a 33rd word.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h100 + 32'(i), 1'b0);
      checkOutput("fill_ready", ready_o, 1'b1);
      tick;
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
      checkOutput("full_ready", ready_o, 1'b0);
      checkOutput("full_margin", margin_o, 6'd0);
      checkOutput("full_req", req_o, 1'b1);
      checkOutput("full_head", data_o, 32'h100);
      tick;
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    checkOutput("full_pop_ready", ready_o, 1'b0);
    tick;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    checkOutput("after_pop_ready", ready_o, 1'b1);
    checkOutput("after_pop_margin", margin_o, 6'd1);
    checkOutput("after_pop_head", data_o, 32'h101);
    tick;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("drain_data", data_o, 32'h100 + 32'(i));
      tick;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drain_last", data_o, 32'h200);
    checkOutput("drain_last_req", req_o, 1'b1);
    tick;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("drained_req", req_o, 1'b0);
    checkOutput("drained_margin", margin_o, 6'd32);

    // Steady state: count held at 5 with simultaneous push and pop.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h300 + 32'(i), 1'b0);
      tick;
    end
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h305 + 32'(k), 1'b1);
      checkOutput("steady_margin", margin_o, 6'd27);
      checkOutput("steady_data", data_o, 32'h300 + 32'(k));
      checkOutput("steady_ready", ready_o, 1'b1);
      tick;
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("steady_drain", data_o, 32'h30A + 32'(i));
      tick;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("steady_empty", margin_o, 6'd32);

    // Disable with 3 words stored: nothing accepted or requested, contents kept.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h41 + 32'(i), 1'b0);
      tick;
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h99, 1'b1);
      checkOutput("dis_req", req_o, 1'b0);
      checkOutput("dis_ready", ready_o, 1'b0);
      checkOutput("dis_margin", margin_o, 6'd29);
      tick;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("reen_req", req_o, 1'b1);
    checkOutput("reen_head", data_o, 32'h41);
    checkOutput("reen_margin", margin_o, 6'd29);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("reen_drain", data_o, 32'h41 + 32'(i));
      tick;
    end

    // Mid-operation reset with 10 words stored, then first push right after.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h500 + 32'(i), 1'b0);
      tick;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("pre_rst_margin", margin_o, 6'd22);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hAB, 1'b0);
    checkOutput("post_rst_req", req_o, 1'b0);
    checkOutput("post_rst_margin", margin_o, 6'd32);
    checkOutput("post_rst_ready", ready_o, 1'b1);
    tick;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("post_rst_push_req", req_o, 1'b1);
    checkOutput("post_rst_push_data", data_o, 32'hAB);
    checkOutput("post_rst_push_margin", margin_o, 6'd31);

`ifdef SLV_PEAK_STAT_EN
    // Peak statistic: sticky maximum until reset.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h700 + 32'(i), 1'b0);
      tick;
    end
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      tick;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("peak_after_drain", peak_o, 6'd7);
    checkOutput("peak_drained_margin", margin_o, 6'd32);
    tick;
    checkOutput("peak_sticky", peak_o, 6'd7);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick;
    checkOutput("peak_reset", peak_o, 6'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slv_chnl_fifo.md
SLV_CHNL_FIFO -- requirements
Module: slv_chnl_fifo

Interface
REQ-001 SHALL have parameter DW, default 32, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning the FIFO depth in words (power of two, 4..256).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en_i  input  1  channel enable from the register block.
REQ-006 SHALL have port valid_i  input  1  upstream initiator word valid.
REQ-007 SHALL have port data_i  input  DW  upstream initiator word.
REQ-008 SHALL have port ready_o  output  1  slave can accept a word this cycle.
REQ-009 SHALL have port req_o  output  1  request to the downstream arbiter; the FIFO is non-empty.
REQ-010 SHALL have port ack_i  input  1  arbiter grant; pops the head word.
REQ-011 SHALL have port data_o  output  DW  head word, show-ahead.
REQ-012 SHALL have port margin_o  output  $clog2(DEPTH)+1  free slots, equal to DEPTH minus the count.
REQ-013 SHALL have port peak_o  output  $clog2(DEPTH)+1  peak occupancy; present only with SLV_PEAK_STAT_EN.

Function
REQ-014 ready_o SHALL equal en_i && !full && !rst, combinationally.
REQ-015 A push SHALL occur when valid_i && ready_o at the rising edge; data_i is written at the write pointer, and the write pointer increments modulo DEPTH.
REQ-016 The pop condition SHALL be ack_i && req_o; the read pointer increments modulo DEPTH. An ack_i without req_o SHALL be ignored, with no state change.
REQ-017 req_o SHALL equal en_i && !empty; data_o SHALL equal mem[rd_ptr] combinationally, valid whenever req_o is high.
REQ-018 Latency: a word pushed at edge N SHALL appear on data_o, with req_o high, after edge N, as the first cycle it is visible. Zero-bubble back-to-back throughput SHALL be 1 word/cycle.
REQ-019 Count behaviour:
  - push only: +1
  - pop only: -1
  - simultaneous push and pop: unchanged
  - full: count == DEPTH
  - empty: count == 0
REQ-020 When full, ready_o SHALL be 0. A simultaneous pop in that cycle SHALL NOT enable a same-cycle push; there is no combinational ready from ack_i.
REQ-021 When empty, a simultaneous valid_i and ack_i SHALL push only; the word becomes visible next cycle.
REQ-022 Pointers SHALL carry one extra wrap bit. full SHALL be (addresses equal, wrap bits differ); empty SHALL be (pointers fully equal).
REQ-023 With en_i low, the block SHALL accept no pushes and present no requests. Stored contents SHALL be retained and resume when en_i returns high.
REQ-024 valid_i held high with ready_o low SHALL NOT alter state. Upstream SHALL hold data_i stable until accepted.

Reset
REQ-025 While rst is high at an edge, the block SHALL:
  - set both pointers and the count to 0
  - drive margin_o = DEPTH
  - drive req_o = 0 and ready_o = 0
  - set peak_o = 0, if present
REQ-026 A mid-operation reset SHALL discard all stored words. The memory array is not cleared, and data_o is don't-care while req_o = 0.
REQ-027 After the cycle in which rst deasserts, the block SHALL accept a push on the first subsequent edge with en_i high.

Configuration
REQ-028 With macro SLV_PEAK_STAT_EN defined, peak_o SHALL exist and register max(peak, next count) each cycle, sticky until rst.
REQ-029 Without SLV_PEAK_STAT_EN, peak_o and its register SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-030 Reset then en_i=1: push 0x11,0x22,0x33 on consecutive cycles -> req_o high from the cycle after the first push; ack each -> data_o 0x11,0x22,0x33 in order; margin_o returns to 32.
REQ-031 Fill scenario, DEPTH=32, no ack -> after 32 accepted words, ready_o=0 and margin_o=0. A 33rd valid_i is held off. One ack -> ready_o=1 next cycle; the 33rd word is accepted; the order is preserved across the pointer wrap.
REQ-032 Steady state with count=5, valid_i and ack_i high together for 10 cycles -> count stays 5, margin_o=27, and the output order matches the input.
REQ-033 en_i=0 with 3 words stored -> req_o=0, ready_o=0, valid_i ignored. en_i=1 -> req_o=1, and the head is still the first word.
REQ-034 Reset asserted for one cycle with 10 words stored -> next cycle req_o=0 and margin_o=32. A subsequent push 0xAB -> data_o=0xAB.
REQ-035 Peak statistic, with SLV_PEAK_STAT_EN: push 7 words, drain all -> peak_o=7 stays after draining; rst -> peak_o=0.
